seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed scan driver for the board's 8-digit common-anode seven-segment display.
- Holds a 32-bit hex value (8 nibbles) and selects one digit at a time. It drives that digit's nibble on `sel` to the downstream hex-to-cathode decoder and the matching active-low anode line.
- Sits between the UART receive/data path, which supplies `value`, and the cathode decoder.
- Provides double-buffered loading, inter-digit blanking (anti-ghosting), per-digit enable and leading-zero suppression.

Parameters:
- NUM_DIGITS, 8, number of digits scanned. Fixed at 8 for this board; `value`/`digit_en` widths follow it.
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz). Must be >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off. Must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe; captures `value`/`digit_en`/`lz_blank` into the pending buffer
- value  in  32  eight hex nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost
- digit_en  in  8  per-digit enable, 1 = digit may light
- lz_blank  in  1  1 = suppress leading zeros
- sel  out  4  nibble of the current digit, to the cathode decoder
- anode  out  8  active-low anode enables; bit i = digit i
- frame_start  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (async assert, sync-safe release):
  - anode = 8'hFF, sel = 0, frame_start = 0.
  - Slot counter = 0, digit index = 0, phase = BLANK.
  - Active value = 0, active mask = 8'hFF, active lz = 0; pending_valid = 0.
  - Reset asserted mid-operation forces anode = 8'hFF immediately.
- Slot counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, digit index increments mod NUM_DIGITS.
- FSM, 2 states:
  - BLANK while counter < BLANK_CYCLES.
  - DRIVE while counter >= BLANK_CYCLES.
  - BLANK->DRIVE when counter reaches BLANK_CYCLES; DRIVE->BLANK on counter wrap.
- Outputs are registered, one cycle behind counter/state:
  - BLANK: anode = 8'hFF.
  - DRIVE: anode = ~(1<<idx) if the digit is visible, else 8'hFF.
  - Per slot: exactly BLANK_CYCLES all-high cycles, then REFRESH_DIV-BLANK_CYCLES drive cycles.
  - First drive cycle of digit 0 appears BLANK_CYCLES+1 cycles after reset release.
- `sel`:
  - Updated at the first cycle of each slot, during BLANK, to the active nibble for idx.
  - Held constant for the whole slot; never changes while an anode is low.
- Visibility:
  - Digit i is visible = active_mask[i] AND NOT lz_suppressed[i].
  - With lz = 1, digits 7..1 are suppressed while they and all higher digits are nibble 0.
  - Digit 0 is never lz-suppressed, so value 0 shows a single "0".
  - With lz = 0, nothing is lz-suppressed.
- Double buffering:
  - On `load`, pending ← {value, digit_en, lz_blank} and pending_valid = 1.
  - A second `load` before commit overwrites pending (last wins).
  - Commit happens on the cycle the index wraps 7->0. Active ← pending, pending_valid = 0, and frame_start pulses that cycle.
  - The new frame's digit 0 uses the new data.
  - `load` coincident with the commit cycle: the new load data is committed directly; no stale pending data survives.
- frame_start pulses every wrap, whether or not a commit occurs. It is 0 during reset.
- Disabled digits keep their slot time, so refresh rate and brightness are independent of the mask.

Decomposition:
- Shared package `seg_pkg`:
  - DIGIT_W = 4
  - ANODE_OFF = 8'hFF
  - phase enum {PH_BLANK, PH_DRIVE}
  - default REFRESH_DIV / BLANK_CYCLES constants
- One sub-module `refresh_prescaler`: parameterised modulo counter emitting the count value and a wrap tick. It is reused by the top for slot timing.
- Leading-zero mask logic stays inline as a combinational function of the active value.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
1. Reset then release, value 0 → anode FF/sel 0 during reset.
   - Then per slot: 2 cycles FF, then 6 cycles with bit idx low (FE, FD, … 7F).
   - sel = 0 throughout; frame_start pulses every 64 cycles.
2. Load 0x1234ABCD, mask FF, mid-frame at digit 3 → remaining slots keep old nibbles.
   - After frame_start: digit0 sel=D, digit1 sel=C, … digit7 sel=1.
3. Load 0x000000A5 with lz_blank=1 → digits 2–7 anode stay FF; digit1 sel=A, digit0 sel=5.
   - Then load 0 with lz=1 → only digit0 drives, sel=0.
4. digit_en=0x0F → anodes for digits 4–7 never low.
   - Slots 4–7 still last 8 cycles each; frame period stays 64.
5. Two loads in one frame (0x11111111 then 0x22222222) → next frame shows all 2s.
   - A load on the exact wrap cycle is committed in that wrap.
6. rst_n asserted while anode=FB in DRIVE → anode FF in the same cycle.
   - After release, timing restarts at digit 0 BLANK with value 0 and mask FF.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants and types for the eight-digit seven-segment scan driver.
//   DIGIT_W          : width of one hex digit (nibble)
//   NUM_DIGITS_DEF   : digits on the board display
//   ANODE_OFF        : anode pattern with every (active-low) anode released
//   REFRESH_DIV_DEF  : default clock cycles per digit slot (1 kHz at 100 MHz)
//   BLANK_CYCLES_DEF : default all-off cycles at the start of each slot
//   phase_e          : slot phase, blanking or driving
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned NUM_DIGITS_DEF   = 8;
    localparam logic [7:0]  ANODE_OFF        = 8'hFF;
    localparam int unsigned REFRESH_DIV_DEF  = 100000;
    localparam int unsigned BLANK_CYCLES_DEF = 1000;

    typedef enum logic [0:0] {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

endpackage : seg_pkg

// File: rtl/seg_scan_driver_prescaler.sv
// -----------------------------------------------------------------------------
// refresh_prescaler
// Free-running modulo-DIV counter. Counts 0..DIV-1 and wraps to 0.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset, counter restarts at 0
//   count_o : current count value
//   wrap_o  : high during the last count (DIV-1); the next edge returns to 0
// -----------------------------------------------------------------------------
module refresh_prescaler #(
    parameter int unsigned DIV = 8,
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] count_o,
    output logic          wrap_o
);

    localparam logic [CW-1:0] LAST_C = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last_s;

    assign last_s = (cnt_q == LAST_C);

    // Next count: wrap to zero after the last value, otherwise increment.
    always_comb begin
        cnt_d = cnt_q;
        if (last_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + ONE_C;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign wrap_o  = last_s;

endmodule : refresh_prescaler

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed scan driver for an eight-digit common-anode display.
// Each digit owns a slot of REFRESH_DIV cycles: BLANK_CYCLES with all anodes
// off (anti-ghosting), then the digit's anode is pulled low if the digit is
// visible. New display data is double-buffered and only takes effect at the
// start of a frame (wrap from digit 7 to digit 0).
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   load        : one-cycle strobe, captures value/digit_en/lz_blank
//   value       : eight hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   digit_en    : per-digit enable, 1 = digit may light
//   lz_blank    : 1 = suppress leading zeros
//   sel         : nibble of the digit in the current slot (to cathode decoder)
//   anode       : active-low anode enables, bit i = digit i
//   frame_start : one-cycle pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int unsigned REFRESH_DIV  = REFRESH_DIV_DEF,
    parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] value,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          lz_blank,
    output logic [DIGIT_W-1:0]            sel,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic                          frame_start
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VW = NUM_DIGITS * DIGIT_W;

    localparam logic [CW-1:0]         CNT_ZERO_C   = {CW{1'b0}};
    localparam logic [CW-1:0]         BLANK_LAST_C = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]         IDX_LAST_C   = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0]         IDX_ONE_C    = IW'(1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF_C    = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] DIGIT0_C     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    // Leading-zero suppression mask: bit i set when digit i and every digit
    // above it hold nibble 0. Digit 0 is never suppressed so an all-zero value
    // still shows a single "0".
    function automatic logic [NUM_DIGITS-1:0] lz_mask_f(input logic [VW-1:0] v,
                                                        input logic          lz);
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = {NUM_DIGITS{1'b0}};
        run = lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run  = run & (v[i*DIGIT_W +: DIGIT_W] == {DIGIT_W{1'b0}});
            m[i] = run;
        end
        return m;
    endfunction

    // ---------------------------------------------------------------- timing
    logic [CW-1:0] cnt_s;
    logic          wrap_s;

    refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_slot_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .count_o (cnt_s),
        .wrap_o  (wrap_s)
    );

    phase_e        phase_q;
    phase_e        phase_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic          commit_s;

    // Commit point: last cycle of digit 7's slot; the next edge starts a frame.
    assign commit_s = wrap_s & (idx_q == IDX_LAST_C);

    // Phase FSM: leave BLANK as the counter reaches BLANK_CYCLES, return on wrap.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_BLANK: begin
                if ((BLANK_CYCLES == 0) || (cnt_s == BLANK_LAST_C)) begin
                    phase_d = PH_DRIVE;
                end else begin
                    phase_d = PH_BLANK;
                end
            end
            PH_DRIVE: begin
                if (wrap_s) begin
                    phase_d = (BLANK_CYCLES == 0) ? PH_DRIVE : PH_BLANK;
                end else begin
                    phase_d = PH_DRIVE;
                end
            end
            default: begin
                phase_d = PH_BLANK;
            end
        endcase
    end

    // Digit index advances once per slot, modulo NUM_DIGITS.
    always_comb begin
        idx_d = idx_q;
        if (wrap_s) begin
            if (idx_q == IDX_LAST_C) begin
                idx_d = {IW{1'b0}};
            end else begin
                idx_d = idx_q + IDX_ONE_C;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Phase and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_BLANK;
            idx_q   <= {IW{1'b0}};
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------- double buffering
    logic [VW-1:0]         pend_val_q;
    logic [NUM_DIGITS-1:0] pend_mask_q;
    logic                  pend_lz_q;
    logic                  pend_vld_q;
    logic [VW-1:0]         act_val_q;
    logic [NUM_DIGITS-1:0] act_mask_q;
    logic                  act_lz_q;

    // Pending buffer: every load overwrites it; a commit empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val_q  <= {VW{1'b0}};
            pend_mask_q <= {NUM_DIGITS{1'b0}};
            pend_lz_q   <= 1'b0;
            pend_vld_q  <= 1'b0;
        end else begin
            if (load) begin
                pend_val_q  <= value;
                pend_mask_q <= digit_en;
                pend_lz_q   <= lz_blank;
            end
            if (commit_s) begin
                pend_vld_q <= 1'b0;
            end else if (load) begin
                pend_vld_q <= 1'b1;
            end
        end
    end

    // Active buffer: updated only at frame commit. A load on the commit cycle
    // bypasses the pending buffer so it cannot be lost or overtaken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_val_q  <= {VW{1'b0}};
            act_mask_q <= {NUM_DIGITS{1'b1}};
            act_lz_q   <= 1'b0;
        end else if (commit_s) begin
            if (load) begin
                act_val_q  <= value;
                act_mask_q <= digit_en;
                act_lz_q   <= lz_blank;
            end else if (pend_vld_q) begin
                act_val_q  <= pend_val_q;
                act_mask_q <= pend_mask_q;
                act_lz_q   <= pend_lz_q;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    logic [DIGIT_W-1:0]    nib_s;
    logic [NUM_DIGITS-1:0] visible_s;
    logic [DIGIT_W-1:0]    sel_q;
    logic [DIGIT_W-1:0]    sel_d;
    logic [NUM_DIGITS-1:0] anode_q;
    logic [NUM_DIGITS-1:0] anode_d;
    logic                  fs_q;
    logic                  fs_d;

    assign nib_s     = act_val_q[idx_q*DIGIT_W +: DIGIT_W];
    assign visible_s = act_mask_q & ~lz_mask_f(act_val_q, act_lz_q);

    // Output next-state. sel only moves on the first (blank) cycle of a slot,
    // so it never changes while an anode is low.
    always_comb begin
        sel_d   = sel_q;
        anode_d = ALL_OFF_C;
        fs_d    = commit_s;
        if (cnt_s == CNT_ZERO_C) begin
            sel_d = nib_s;
        end else begin
            sel_d = sel_q;
        end
        if ((phase_q == PH_DRIVE) && visible_s[idx_q]) begin
            anode_d = ~(DIGIT0_C << idx_q);
        end else begin
            anode_d = ALL_OFF_C;
        end
    end

    // Output registers; reset releases every anode asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= {DIGIT_W{1'b0}};
            anode_q <= ALL_OFF_C;
            fs_q    <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            anode_q <= anode_d;
            fs_q    <= fs_d;
        end
    end

    assign sel         = sel_q;
    assign anode       = anode_q;
    assign frame_start = fs_q;

endmodule : seg_scan_driver

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = DIV * 8;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic        lz_blank;
    logic [3:0]  sel;
    logic [7:0]  anode;
    logic        frame_start;

    seg_scan_driver #(
        .NUM_DIGITS   (8),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .digit_en    (digit_en),
        .lz_blank    (lz_blank),
        .sel         (sel),
        .anode       (anode),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0] an;
        logic [3:0] sel;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: edges since reset release, committed and pending data
    int          m_n;
    logic [31:0] m_val, p_val;
    logic [7:0]  m_mask, p_mask;
    logic        m_lz, p_lz, p_vld;
    logic [3:0]  m_sel;

    function automatic logic [3:0] nib(input logic [31:0] v, input int i);
        logic [31:0] t;
        t = (v >> (4 * i)) & 32'h0000_000F;
        return t[3:0];
    endfunction

    // Visible if enabled and, with lz on, not above the highest nonzero digit.
    function automatic logic visible(input int i);
        int h;
        h = 0;
        for (int k = 0; k < 8; k++) if (nib(m_val, k) != 4'h0) h = k;
        if (!m_mask[i]) return 1'b0;
        if (!m_lz) return 1'b1;
        return (i <= h);
    endfunction

    task automatic model_step();
        exp_t e;
        int s, c, idx;
        if (!rst_n) begin
            m_n = 0; m_val = 32'h0; m_mask = 8'hFF; m_lz = 1'b0; p_vld = 1'b0; m_sel = 4'h0;
            e.an = 8'hFF; e.sel = 4'h0; e.fs = 1'b0;
        end else begin
            m_n++;
            s   = m_n - 1;
            c   = s % DIV;
            idx = (s / DIV) % 8;
            if (c == 0) m_sel = nib(m_val, idx);
            e.sel = m_sel;
            e.an  = (c >= BLANK && visible(idx)) ? ~(8'd1 << idx) : 8'hFF;
            e.fs  = ((s % FRAME) == FRAME - 1);
            if ((s % FRAME) == FRAME - 1) begin
                if (load) begin
                    m_val = value; m_mask = digit_en; m_lz = lz_blank;
                end else if (p_vld) begin
                    m_val = p_val; m_mask = p_mask; m_lz = p_lz;
                end
                p_vld = 1'b0;
            end else if (load) begin
                p_val = value; p_mask = digit_en; p_lz = lz_blank; p_vld = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    // Model advances on every active edge and queues the expected outputs.
    initial begin
        m_n = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Scoreboard: compare DUT outputs against queued expectations on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("anode", {24'h0, anode}, {24'h0, e.an});
                check_val("sel", {28'h0, sel}, {28'h0, e.sel});
                check_val("frame_start", {31'h0, frame_start}, {31'h0, e.fs});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until the model position within the frame equals target.
    task automatic wait_pos(input string tag, input int target);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if ((m_n % FRAME) == target) break;
            @(negedge clk);
        end
        if ((m_n % FRAME) != target) check_val(tag, m_n % FRAME, target);
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] en, input logic lz);
        load = 1'b1; value = v; digit_en = en; lz_blank = lz;
        @(negedge clk);
        load = 1'b0; value = 32'h0; digit_en = 8'h00; lz_blank = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; value = 32'h0; digit_en = 8'h00; lz_blank = 1'b0;
        idle(3);
        #1;
        check_val("rst_anode", {24'h0, anode}, 32'hFF);
        check_val("rst_sel", {28'h0, sel}, 32'h0);
        check_val("rst_fs", {31'h0, frame_start}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: power-up value 0, all digits lit in turn
        idle(2 * FRAME + 4);

        // 2: mid-frame load at digit 3
        wait_pos("sync_t2", 25);
        do_load(32'h1234ABCD, 8'hFF, 1'b0);
        idle(2 * FRAME);

        // 3: leading-zero suppression
        wait_pos("sync_t3a", 10);
        do_load(32'h000000A5, 8'hFF, 1'b1);
        idle(2 * FRAME);
        wait_pos("sync_t3b", 10);
        do_load(32'h00000000, 8'hFF, 1'b1);
        idle(2 * FRAME);

        // 4: digits 4..7 disabled
        wait_pos("sync_t4", 30);
        do_load(32'h87654321, 8'h0F, 1'b0);
        idle(2 * FRAME);

        // 5: last load wins; load on the wrap cycle is committed directly
        wait_pos("sync_t5a", 5);
        do_load(32'h11111111, 8'hFF, 1'b0);
        wait_pos("sync_t5b", 40);
        do_load(32'h22222222, 8'hFF, 1'b0);
        idle(FRAME + 8);
        wait_pos("sync_t5c", 10);
        do_load(32'h44444444, 8'hFF, 1'b0);
        wait_pos("sync_t5d", FRAME - 1);
        do_load(32'h33333333, 8'hFF, 1'b0);
        idle(FRAME + 10);

        // 6: asynchronous reset while digit 2 drives
        wait_pos("sync_t6", 20);
        check_val("pre_rst_anode", {24'h0, anode}, 32'hFB);
        #1 rst_n = 1'b0;
        #1;
        check_val("async_rst_anode", {24'h0, anode}, 32'hFF);
        check_val("async_rst_sel", {28'h0, sel}, 32'h0);
        idle(3);
        rst_n = 1'b1;
        idle(FRAME + 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seg_scan_driver
